// File: rtl/fare_payer.sv
// Customer-side payer: drives a purchase to the ticket vendor, inserts coins, then tallies returns.
// Optional FARE_PAYER_ABORT_EN adds i_abort to cut coin insertion short.
module fare_payer #(
  parameter int unsigned DEST_W    = 8,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned IDLE_DEST = 16,
  parameter int unsigned GAP       = 1,
  parameter int unsigned DONE_CYC  = 2,
  parameter int unsigned QUIET     = 16,
  parameter int unsigned VAL_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [DEST_W-1:0] i_dest_in,
  input  logic [CNT_W-1:0]  i_count_in,
  input  logic [CNT_W-1:0]  i_ones_in,
  input  logic [CNT_W-1:0]  i_tens_in,
`ifdef FARE_PAYER_ABORT_EN
  input  logic              i_abort,
`endif
  input  logic              i_ticket,
  input  logic              i_one_output,
  input  logic              i_ten_output,
  output logic [DEST_W-1:0] o_dest,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_one_insert,
  output logic              o_ten_insert,
  output logic              o_done,
  output logic              o_busy,
  output logic              o_result_valid,
  output logic [CNT_W-1:0]  o_tickets_got,
  output logic [VAL_W-1:0]  o_change_total
);

  typedef enum logic [3:0] {
    StIdle, StLoad, StOne, StOneGap, StTen, StTenGap, StDone, StCollect, StReport
  } state_t;

  localparam logic [DEST_W-1:0] IdleDest  = DEST_W'(IDLE_DEST);
  localparam logic [15:0]       GapLast   = 16'(GAP - 1);
  localparam logic [15:0]       DoneLast  = 16'(DONE_CYC - 1);
  localparam logic [15:0]       QuietLast = 16'(QUIET - 1);

  state_t              r_state;
  logic [DEST_W-1:0]   r_dest;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    r_ones;
  logic [CNT_W-1:0]    r_tens;
  logic [15:0]         r_cnt;
  logic                r_one_insert;
  logic                r_ten_insert;
  logic                r_done;
  logic                r_busy;
  logic                r_result_valid;
  logic [CNT_W-1:0]    r_tickets;
  logic [VAL_W-1:0]    r_change;

  logic                w_abort;
  logic                w_pulse;
  logic                w_count_en;
  state_t              w_next_coin;
  state_t              w_adv_state;
  logic [4:0]          w_change_step;
  logic [VAL_W:0]      w_change_sum;
  logic [VAL_W-1:0]    w_change_sat;
  logic [CNT_W-1:0]    w_tickets_next;

`ifdef FARE_PAYER_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_pulse     = i_ticket | i_one_output | i_ten_output;
  assign w_count_en  = (r_state != StIdle) && (r_state != StReport);
  // All ones go before any tens; an empty request falls straight through to DONE.
  assign w_next_coin = (r_ones != '0) ? StOne : ((r_tens != '0) ? StTen : StDone);
  assign w_adv_state = w_abort ? StDone : w_next_coin;

  assign w_change_step  = (i_one_output ? 5'd1 : 5'd0) + (i_ten_output ? 5'd10 : 5'd0);
  assign w_change_sum   = {1'b0, r_change} + (VAL_W+1)'(w_change_step);
  assign w_change_sat   = w_change_sum[VAL_W] ? '1 : w_change_sum[VAL_W-1:0];
  assign w_tickets_next = (i_ticket && (r_tickets != '1)) ? r_tickets + 1'b1 : r_tickets;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StIdle;
      r_dest         <= IdleDest;
      r_count        <= '0;
      r_ones         <= '0;
      r_tens         <= '0;
      r_cnt          <= '0;
      r_one_insert   <= 1'b0;
      r_ten_insert   <= 1'b0;
      r_done         <= 1'b0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_tickets      <= '0;
      r_change       <= '0;
    end else begin
      r_one_insert   <= 1'b0;
      r_ten_insert   <= 1'b0;
      r_result_valid <= 1'b0;
      if (w_count_en) begin
        r_tickets <= w_tickets_next;
        r_change  <= w_change_sat;
      end
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_dest    <= i_dest_in;
            r_count   <= i_count_in;
            r_ones    <= i_ones_in;
            r_tens    <= i_tens_in;
            r_tickets <= '0;
            r_change  <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= StLoad;
          end
        end
        StLoad: begin
          r_state      <= w_adv_state;
          r_one_insert <= (w_adv_state == StOne);
          r_ten_insert <= (w_adv_state == StTen);
          r_done       <= (w_adv_state == StDone);
          r_cnt        <= '0;
        end
        StOne: begin
          r_ones  <= r_ones - 1'b1;
          r_cnt   <= '0;
          r_done  <= w_abort;
          r_state <= w_abort ? StDone : StOneGap;
        end
        StTen: begin
          r_tens  <= r_tens - 1'b1;
          r_cnt   <= '0;
          r_done  <= w_abort;
          r_state <= w_abort ? StDone : StTenGap;
        end
        StOneGap, StTenGap: begin
          if (w_abort || (r_cnt == GapLast)) begin
            r_state      <= w_adv_state;
            r_one_insert <= (w_adv_state == StOne);
            r_ten_insert <= (w_adv_state == StTen);
            r_done       <= (w_adv_state == StDone);
            r_cnt        <= '0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        StDone: begin
          if (r_cnt == DoneLast) begin
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_state <= StCollect;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        StCollect: begin
          // Any return pulse restarts the quiet window.
          if (w_pulse) begin
            r_cnt <= '0;
          end else if (r_cnt == QuietLast) begin
            r_result_valid <= 1'b1;
            r_state        <= StReport;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        StReport: begin
          r_busy  <= 1'b0;
          r_dest  <= IdleDest;
          r_count <= '0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_dest         = r_dest;
  assign o_count        = r_count;
  assign o_one_insert   = r_one_insert;
  assign o_ten_insert   = r_ten_insert;
  assign o_done         = r_done;
  assign o_busy         = r_busy;
  assign o_result_valid = r_result_valid;
  assign o_tickets_got  = r_tickets;
  assign o_change_total = r_change;

endmodule

// File: tb/tb_fare_payer.sv
// Directed bench for fare_payer: table of purchases with hand-computed timing and totals,
// plus reset-abort and (with FARE_PAYER_ABORT_EN) abort sequences.
module tb_fare_payer;

  logic       clk;
  logic       rst_n;
  logic       i_start;
  logic [7:0] i_dest_in;
  logic [7:0] i_count_in;
  logic [7:0] i_ones_in;
  logic [7:0] i_tens_in;
`ifdef FARE_PAYER_ABORT_EN
  logic       i_abort;
`endif
  logic       i_ticket;
  logic       i_one_output;
  logic       i_ten_output;
  logic [7:0]  o_dest;
  logic [7:0]  o_count;
  logic        o_one_insert;
  logic        o_ten_insert;
  logic        o_done;
  logic        o_busy;
  logic        o_result_valid;
  logic [7:0]  o_tickets_got;
  logic [15:0] o_change_total;

  fare_payer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (i_start),
    .i_dest_in      (i_dest_in),
    .i_count_in     (i_count_in),
    .i_ones_in      (i_ones_in),
    .i_tens_in      (i_tens_in),
`ifdef FARE_PAYER_ABORT_EN
    .i_abort        (i_abort),
`endif
    .i_ticket       (i_ticket),
    .i_one_output   (i_one_output),
    .i_ten_output   (i_ten_output),
    .o_dest         (o_dest),
    .o_count        (o_count),
    .o_one_insert   (o_one_insert),
    .o_ten_insert   (o_ten_insert),
    .o_done         (o_done),
    .o_busy         (o_busy),
    .o_result_valid (o_result_valid),
    .o_tickets_got  (o_tickets_got),
    .o_change_total (o_change_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  typedef struct {
    int dest, count, ones, tens;
    int rt, ro, rn;            // ticket / one / ten return pulses sent by the vendor model
    int restart_at;            // cycle of a second start while busy (0 = none)
    int exp_first_one, exp_first_ten, exp_done_at, exp_valid_at;
    int exp_tickets, exp_change;
  } vec_t;

  vec_t vecs[6];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int first_one = 0, first_ten = 0, n_one = 0, n_ten = 0, overlap = 0;
    int done_at = 0, done_len = 0, ret_start = -1, valid_at = 0, n_valid = 0;
    int tk = -1, ch = -1, hold_err = 0, dest_after = -1, busy_after = -1, tk_after = -1;
    int load_busy = 0, load_dest = -1, load_count = -1;
    bit fin = 0;
    string p;
    p = $sformatf("v%0d", idx);
    @(negedge clk);
    i_dest_in  = 8'(v.dest);
    i_count_in = 8'(v.count);
    i_ones_in  = 8'(v.ones);
    i_tens_in  = 8'(v.tens);
    i_start    = 1'b1;
    for (int c = 1; c <= v.exp_valid_at + 40 && !fin; c++) begin
      @(negedge clk);
      if (c == 1) begin
        load_busy  = int'(o_busy);
        load_dest  = int'(o_dest);
        load_count = int'(o_count);
      end
      if (o_one_insert) begin n_one++; if (first_one == 0) first_one = c; end
      if (o_ten_insert) begin n_ten++; if (first_ten == 0) first_ten = c; end
      if (o_one_insert && o_ten_insert) overlap++;
      if (o_done) begin if (done_at == 0) done_at = c; done_len++; end
      if (done_at != 0 && !o_done && ret_start < 0) ret_start = c;
      if (o_busy && int'(o_dest) != v.dest) hold_err++;
      if (o_result_valid) begin
        n_valid++;
        valid_at = c;
        tk = int'(o_tickets_got);
        ch = int'(o_change_total);
      end
      if (valid_at != 0 && c == valid_at + 1) begin
        dest_after = int'(o_dest);
        busy_after = int'(o_busy);
        tk_after   = int'(o_tickets_got);
      end
      if (valid_at != 0 && c == valid_at + 3) fin = 1;
      i_start   = (c == v.restart_at);
      i_dest_in = (c == v.restart_at) ? 8'd99 : 8'(v.dest);
      if (ret_start >= 0) begin
        i_ticket     = (c - ret_start) < v.rt;
        i_one_output = (c - ret_start) < v.ro;
        i_ten_output = (c - ret_start) < v.rn;
      end
    end
    i_start = 1'b0; i_ticket = 1'b0; i_one_output = 1'b0; i_ten_output = 1'b0;
    chk({p, " busy_at_load"}, load_busy, 1);
    chk({p, " dest_at_load"}, load_dest, v.dest);
    chk({p, " count_at_load"}, load_count, v.count);
    chk({p, " first_one"}, first_one, v.exp_first_one);
    chk({p, " first_ten"}, first_ten, v.exp_first_ten);
    chk({p, " n_one"}, n_one, v.ones);
    chk({p, " n_ten"}, n_ten, v.tens);
    chk({p, " insert_overlap"}, overlap, 0);
    chk({p, " done_at"}, done_at, v.exp_done_at);
    chk({p, " done_len"}, done_len, 2);
    chk({p, " valid_at"}, valid_at, v.exp_valid_at);
    chk({p, " n_valid"}, n_valid, 1);
    chk({p, " tickets_got"}, tk, v.exp_tickets);
    chk({p, " change_total"}, ch, v.exp_change);
    chk({p, " dest_held"}, hold_err, 0);
    chk({p, " dest_after"}, dest_after, 16);
    chk({p, " busy_after"}, busy_after, 0);
    chk({p, " tickets_hold"}, tk_after, v.exp_tickets);
  endtask

  initial begin
    int act;
    rst_n = 1'b0; i_start = 1'b0; i_dest_in = '0; i_count_in = '0; i_ones_in = '0;
    i_tens_in = '0; i_ticket = 1'b0; i_one_output = 1'b0; i_ten_output = 1'b0;
`ifdef FARE_PAYER_ABORT_EN
    i_abort = 1'b0;
`endif
    //          dst cnt 1s 10s  rt  ro rn rst  f1 f10 dn  val   tk  chg
    vecs[0] = '{15, 3,  2, 1,   3,  6, 0, 0,   2, 6,  8,  32,   3,  6};
    vecs[1] = '{20, 1,  0, 0,   0,  0, 0, 0,   0, 0,  2,  20,   0,  0};
    vecs[2] = '{21, 2,  0, 0,   2,  2, 2, 0,   0, 0,  2,  22,   2,  22};
    vecs[3] = '{15, 3,  2, 1,   3,  6, 0, 6,   2, 6,  8,  32,   3,  6};
    vecs[4] = '{5,  1,  1, 2,   1,  0, 3, 0,   2, 4,  8,  29,   1,  30};
    vecs[5] = '{9,  4,  0, 0,   260, 0, 0, 0,  0, 0,  2,  280,  255, 0};

    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {o_dest, o_count, o_one_insert, o_ten_insert, o_done, o_busy, o_result_valid,
         o_tickets_got, o_change_total},
        {8'd16, 8'd0, 5'b0, 8'd0, 16'd0});
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Reset asserted while in ONE_GAP must clear everything without waiting for a clock edge.
    @(negedge clk);
    i_dest_in = 8'd7; i_count_in = 8'd2; i_ones_in = 8'd3; i_tens_in = 8'd1; i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    @(negedge clk);
    chk("rst_mid one_insert_before", o_one_insert, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid async_outputs",
        {o_dest, o_count, o_one_insert, o_ten_insert, o_done, o_busy, o_result_valid,
         o_tickets_got, o_change_total},
        {8'd16, 8'd0, 5'b0, 8'd0, 16'd0});
    @(negedge clk); rst_n = 1'b1;
    act = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (o_one_insert || o_ten_insert || o_done || o_busy || o_result_valid) act++;
    end
    chk("rst_mid quiet_after_release", act, 0);
    run_vec(6, vecs[1]);

`ifdef FARE_PAYER_ABORT_EN
    begin
      int n1 = 0, n10 = 0, dn = 0, vl = 0;
      @(negedge clk);
      i_dest_in = 8'd3; i_count_in = 8'd1; i_ones_in = 8'd5; i_tens_in = 8'd2; i_start = 1'b1;
      for (int c = 1; c <= 60; c++) begin
        @(negedge clk);
        i_start = 1'b0;
        if (o_one_insert) n1++;
        if (o_ten_insert) n10++;
        if (o_done && dn == 0) dn = c;
        if (o_result_valid) vl++;
        i_abort = o_one_insert && (n1 == 2);
      end
      i_abort = 1'b0;
      chk("abort n_one", n1, 2);
      chk("abort n_ten", n10, 0);
      chk("abort done_at", dn, 5);
      chk("abort n_valid", vl, 1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
